// File: rtl/id_ex_stage.sv
// Decode/execute pipeline register with load-use bubble, flush, hold and a saturating stall counter.
// Optional write-before-read operand bypass on capture: define ID_EX_WB_BYPASS_EN.
module id_ex_stage #(
   parameter int DATA_W   = 16,
   parameter int REG_ID_W = 4,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [3:0]          id_opcode,
   input  logic [REG_ID_W-1:0] id_src1,
   input  logic [REG_ID_W-1:0] id_src2,
   input  logic [REG_ID_W-1:0] id_dst,
   input  logic                id_regwrite,
   input  logic                id_memread,
   input  logic [DATA_W-1:0]   id_imm,
   input  logic [DATA_W-1:0]   rf_data1,
   input  logic [DATA_W-1:0]   rf_data2,
   input  logic                wb_regwrite,
   input  logic [REG_ID_W-1:0] wb_dst,
   input  logic [DATA_W-1:0]   wb_data,
   input  logic                flush,
   input  logic                ex_hold,
   output logic                stall_up,
   output logic                ex_valid,
   output logic [3:0]          ex_opcode,
   output logic [REG_ID_W-1:0] ex_src1,
   output logic [REG_ID_W-1:0] ex_src2,
   output logic [REG_ID_W-1:0] ex_dst,
   output logic                ex_regwrite,
   output logic                ex_memread,
   output logic [DATA_W-1:0]   ex_data1,
   output logic [DATA_W-1:0]   ex_data2,
   output logic [DATA_W-1:0]   ex_imm,
   output logic [CNT_W-1:0]    stall_cnt
);

   logic              load_use;
   logic              src1_match;
   logic              src2_match;
   logic [DATA_W-1:0] cap_data1;
   logic [DATA_W-1:0] cap_data2;

   assign src1_match = (id_src1 == ex_dst);
   assign src2_match = (id_src2 == ex_dst);

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign load_use = ex_valid & ex_memread & ex_regwrite & (ex_dst != '0) &
                     id_valid & (src1_match | src2_match);

   assign stall_up = ex_hold | (load_use & ~flush);

`ifdef ID_EX_WB_BYPASS_EN
   assign cap_data1 = (wb_regwrite && (wb_dst != '0) && (wb_dst == id_src1)) ? wb_data : rf_data1;
   assign cap_data2 = (wb_regwrite && (wb_dst != '0) && (wb_dst == id_src2)) ? wb_data : rf_data2;
`else
   logic unused_wb;
   assign unused_wb = ^{wb_regwrite, wb_dst, wb_data};
   assign cap_data1 = rf_data1;
   assign cap_data2 = rf_data2;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_opcode   <= '0;
         ex_src1     <= '0;
         ex_src2     <= '0;
         ex_dst      <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_data1    <= '0;
         ex_data2    <= '0;
         ex_imm      <= '0;
      end else if (flush) begin
         ex_valid    <= 1'b0;
         ex_opcode   <= '0;
         ex_src1     <= '0;
         ex_src2     <= '0;
         ex_dst      <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_data1    <= '0;
         ex_data2    <= '0;
         ex_imm      <= '0;
      end else if (ex_hold) begin
         ex_valid    <= ex_valid;
      end else if (load_use) begin
         // Bubble: the dependent instruction stays in decode and is re-presented next cycle.
         ex_valid    <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
      end else begin
         ex_valid    <= id_valid;
         ex_opcode   <= id_opcode;
         ex_src1     <= id_src1;
         ex_src2     <= id_src2;
         ex_dst      <= id_dst;
         ex_regwrite <= id_regwrite & id_valid;
         ex_memread  <= id_memread & id_valid;
         ex_data1    <= cap_data1;
         ex_data2    <= cap_data2;
         ex_imm      <= id_imm;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_up && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage: behavioural EX-slot model checked every cycle plus directed literal cases.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [3:0]  id_opcode;
   logic [3:0]  id_src1, id_src2, id_dst;
   logic        id_regwrite, id_memread;
   logic [15:0] id_imm, rf_data1, rf_data2;
   logic        wb_regwrite;
   logic [3:0]  wb_dst;
   logic [15:0] wb_data;
   logic        flush, ex_hold;
   logic        stall_up, ex_valid;
   logic [3:0]  ex_opcode, ex_src1, ex_src2, ex_dst;
   logic        ex_regwrite, ex_memread;
   logic [15:0] ex_data1, ex_data2, ex_imm, stall_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Model of the EX slot: what execute should currently see.
   logic        m_valid, m_rw, m_mr;
   logic [3:0]  m_op, m_s1, m_s2, m_dst;
   logic [15:0] m_d1, m_d2, m_imm;
   bit          m_known;
   int          m_cnt;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_src1(id_src1), .id_src2(id_src2), .id_dst(id_dst),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_imm(id_imm),
      .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_regwrite(wb_regwrite),
      .wb_dst(wb_dst), .wb_data(wb_data), .flush(flush), .ex_hold(ex_hold),
      .stall_up(stall_up), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dst(ex_dst),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_data1(ex_data1),
      .ex_data2(ex_data2), .ex_imm(ex_imm), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] capture(input logic [3:0] s, input logic [15:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
      if (wb_regwrite && wb_dst != 4'd0 && wb_dst == s) return wb_data;
`endif
      return rf;
   endfunction

   task automatic model_reset();
      {m_valid, m_rw, m_mr} = 3'b000;
      {m_op, m_s1, m_s2, m_dst} = 16'h0;
      {m_d1, m_d2, m_imm} = 48'h0;
      m_known = 1'b1;
      m_cnt = 0;
   endtask

   // Compare at the falling edge (inputs and outputs stable), then advance the model.
   always @(negedge clk) begin
      if (rst) begin
         model_reset();
      end else if (chk_en) begin
         bit lu, st;
         lu = m_valid && m_mr && m_rw && m_dst != 0 && id_valid &&
              (id_src1 == m_dst || id_src2 == m_dst);
         st = ex_hold || (lu && !flush);
         chk("ex_valid", ex_valid, m_valid);
         chk("ex_regwrite", ex_regwrite, m_rw);
         chk("ex_memread", ex_memread, m_mr);
         chk("stall_up", stall_up, st);
         chk("stall_cnt", stall_cnt, m_cnt);
         if (m_valid || m_known) begin
            chk("ex_opcode", ex_opcode, m_op);
            chk("ex_src1", ex_src1, m_s1);
            chk("ex_src2", ex_src2, m_s2);
            chk("ex_dst", ex_dst, m_dst);
            chk("ex_data1", ex_data1, m_d1);
            chk("ex_data2", ex_data2, m_d2);
            chk("ex_imm", ex_imm, m_imm);
         end
         if (st) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
         if (flush) begin
            {m_valid, m_rw, m_mr} = 3'b000;
            {m_op, m_s1, m_s2, m_dst} = 16'h0;
            {m_d1, m_d2, m_imm} = 48'h0;
            m_known = 1'b1;
         end else if (ex_hold) begin
            m_known = m_known;
         end else if (lu) begin
            {m_valid, m_rw, m_mr} = 3'b000;
            m_known = 1'b0;
         end else begin
            m_valid = id_valid;
            m_rw    = id_regwrite && id_valid;
            m_mr    = id_memread && id_valid;
            m_op = id_opcode; m_s1 = id_src1; m_s2 = id_src2; m_dst = id_dst;
            m_d1 = capture(id_src1, rf_data1);
            m_d2 = capture(id_src2, rf_data2);
            m_imm = id_imm;
            m_known = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      id_valid = 0; id_opcode = 0; id_src1 = 0; id_src2 = 0; id_dst = 0;
      id_regwrite = 0; id_memread = 0; id_imm = 0; rf_data1 = 0; rf_data2 = 0;
      wb_regwrite = 0; wb_dst = 0; wb_data = 0; flush = 0; ex_hold = 0;
   endtask

   task automatic set_id(input logic [3:0] op, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] d, input logic rw, input logic mr,
                         input logic [15:0] d1, input logic [15:0] d2);
      id_valid = 1; id_opcode = op; id_src1 = s1; id_src2 = s2; id_dst = d;
      id_regwrite = rw; id_memread = mr; rf_data1 = d1; rf_data2 = d2; id_imm = 16'h0042;
   endtask

   task automatic do_reset();
      rst = 1;
      #1;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_data1", ex_data1, 16'h0000);
      chk("rst_stall_cnt", stall_cnt, 16'h0000);
      step();
      rst = 0;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      chk_en = 1;
      #12 rst = 0;
      step();
      chk("init_ex_valid", ex_valid, 0);
      chk("init_stall_up", stall_up, 0);

      // Normal flow
      set_id(4'h0, 4'd3, 4'd4, 4'd5, 1, 0, 16'h1234, 16'h00FF);
      step();
      chk("flow_valid", ex_valid, 1);
      chk("flow_data1", ex_data1, 16'h1234);
      chk("flow_data2", ex_data2, 16'h00FF);
      chk("flow_dst", ex_dst, 5);
      chk("flow_stall_up", stall_up, 0);

      // Load-use on r2: one bubble, then the dependent op enters EX
      set_id(4'h8, 4'd0, 4'd0, 4'd2, 1, 1, 16'h0, 16'h0);
      step();
      set_id(4'h1, 4'd2, 4'd7, 4'd6, 1, 0, 16'h1111, 16'h2222);
      #1 chk("lu_stall_up", stall_up, 1);
      step();
      chk("lu_bubble_valid", ex_valid, 0);
      chk("lu_after_bubble_stall", stall_up, 0);
      step();
      chk("lu_dep_valid", ex_valid, 1);
      chk("lu_dep_opcode", ex_opcode, 4'h1);
      chk("lu_dep_data1", ex_data1, 16'h1111);
      chk("lu_stall_cnt", stall_cnt, 1);

      // Load to r0 never stalls
      set_id(4'h8, 4'd0, 4'd0, 4'd0, 1, 1, 16'h0, 16'h0);
      step();
      set_id(4'h1, 4'd0, 4'd0, 4'd6, 1, 0, 16'h3333, 16'h4444);
      #1 chk("r0_stall_up", stall_up, 0);
      step();
      chk("r0_dep_valid", ex_valid, 1);
      chk("r0_dep_data1", ex_data1, 16'h3333);

      // Asynchronous reset mid-cycle with a live EX slot
      do_reset();

      // Hold for three cycles, then flush beats hold
      set_id(4'h2, 4'd1, 4'd2, 4'd9, 1, 0, 16'hA5A5, 16'h5A5A);
      step();
      set_id(4'h3, 4'd4, 4'd5, 4'd6, 1, 0, 16'h7777, 16'h8888);
      ex_hold = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_data1", ex_data1, 16'hA5A5);
         chk("hold_valid", ex_valid, 1);
      end
      chk("hold_stall_cnt", stall_cnt, 3);
      flush = 1;
      step();
      chk("flush_hold_valid", ex_valid, 0);
      chk("flush_hold_data1", ex_data1, 16'h0000);
      flush = 0; ex_hold = 0;

      // Same-cycle writeback to the source register
      set_id(4'h4, 4'd3, 4'd1, 4'd7, 1, 0, 16'h0001, 16'h0002);
      wb_regwrite = 1; wb_dst = 4'd3; wb_data = 16'hBEEF;
      step();
`ifdef ID_EX_WB_BYPASS_EN
      chk("bypass_data1", ex_data1, 16'hBEEF);
`else
      chk("bypass_data1", ex_data1, 16'h0001);
`endif
      wb_dst = 4'd0;
      id_src1 = 4'd0;
      step();
      chk("bypass_r0_data1", ex_data1, 16'h0001);
      idle_inputs();

      // Randomized traffic, small register range to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         id_valid    = ($urandom_range(0, 9) < 8);
         id_opcode   = 4'($urandom);
         id_src1     = 4'($urandom_range(0, 3));
         id_src2     = 4'($urandom_range(0, 3));
         id_dst      = 4'($urandom_range(0, 3));
         id_regwrite = ($urandom_range(0, 3) != 0);
         id_memread  = ($urandom_range(0, 2) == 0);
         id_imm      = 16'($urandom);
         rf_data1    = 16'($urandom);
         rf_data2    = 16'($urandom);
         wb_regwrite = $urandom_range(0, 1);
         wb_dst      = 4'($urandom_range(0, 3));
         wb_data     = 16'($urandom);
         flush       = ($urandom_range(0, 9) == 0);
         ex_hold     = ($urandom_range(0, 9) == 0);
         step();
      end
      idle_inputs();

      // Saturation of the stall counter
      do_reset();
      ex_hold = 1;
      for (int i = 0; i < 65536; i++) step();
      chk("sat_cnt", stall_cnt, 16'hFFFF);
      step();
      chk("sat_cnt_nowrap", stall_cnt, 16'hFFFF);
      ex_hold = 0;
      step();

      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
